// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter PUF array: FSM states, challenge
// scrambling (used when PUF_CHAL_SCRAMBLE_EN is defined), parameter legality checks.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FIRE,
    SAMPLE,
    VOTE,
    HOLD
  } puf_state_e;

  localparam int unsigned CHAL_MAX = 64;
  localparam int unsigned CHAL_IW  = $clog2(CHAL_MAX);

  // Rotate the low len bits of chal left by idx mod len, then invert them all for odd idx.
  function automatic logic [CHAL_MAX-1:0] chal_scramble(input logic [CHAL_MAX-1:0] chal,
                                                        input int unsigned len,
                                                        input int unsigned idx);
    logic [CHAL_MAX-1:0] v_out;
    int unsigned         v_rot;
    v_out = '0;
    v_rot = idx % len;
    for (int unsigned b = 0; b < len; b++) begin
      v_out[CHAL_IW'((b + v_rot) % len)] = chal[CHAL_IW'(b)] ^ idx[0];
    end
    return v_out;
  endfunction

  function automatic bit n_eval_legal(input int unsigned n);
    return (n >= 1) && (n % 2 == 1);
  endfunction

  function automatic bit settle_legal(input int unsigned s);
    return s >= 3;
  endfunction

  function automatic bit c_length_legal(input int unsigned c);
    return (c >= 1) && (c <= CHAL_MAX);
  endfunction

endpackage

// File: rtl/puf_chain.sv
// One arbiter PUF delay line: C_LENGTH crossed/straight mux pairs racing a launch
// edge, resolved by an arbiter flop clocked by path A that samples path B.
module puf_chain #(
  parameter int unsigned C_LENGTH = 8
) (
  input  logic                i_launch,
  input  logic [C_LENGTH-1:0] i_challenge,
  output logic                o_arb
);

  (* dont_touch = "true" *) logic [C_LENGTH:0] w_a;
  (* dont_touch = "true" *) logic [C_LENGTH:0] w_b;
  (* dont_touch = "true" *) logic              r_arb;

  assign w_a[0] = i_launch;
  assign w_b[0] = i_launch;

  for (genvar s = 0; s < C_LENGTH; s++) begin : g_stage
    assign w_a[s+1] = i_challenge[s] ? w_b[s] : w_a[s];
    assign w_b[s+1] = i_challenge[s] ? w_a[s] : w_b[s];
  end

  // Deliberately unreset: its value is the physical race outcome.
  always_ff @(posedge w_a[C_LENGTH]) begin
    r_arb <= w_b[C_LENGTH];
  end

  assign o_arb = r_arb;

endmodule

// File: rtl/arbiter_puf_array.sv
// Multi-chain arbiter PUF engine: FSM-driven launch, 2-flop sync, majority vote over
// N_EVAL races, valid/ready result. Define PUF_CHAL_SCRAMBLE_EN to decorrelate chain challenges.
module arbiter_puf_array
  import puf_pkg::*;
#(
  parameter int unsigned C_LENGTH   = 8,
  parameter int unsigned N_CHAINS   = 4,
  parameter int unsigned N_EVAL     = 5,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [C_LENGTH-1:0] challenge,
  output logic                busy,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [N_CHAINS-1:0] response,
  output logic [N_CHAINS-1:0] stable
);

  localparam int unsigned CW = $clog2(N_EVAL + 1);
  localparam int unsigned PW = $clog2(SETTLE_CYC);

  if (!n_eval_legal(N_EVAL)) begin : g_bad_n_eval
    $error("arbiter_puf_array: N_EVAL must be odd and >= 1");
  end
  if (!settle_legal(SETTLE_CYC)) begin : g_bad_settle
    $error("arbiter_puf_array: SETTLE_CYC must be >= 3");
  end
  if (!c_length_legal(C_LENGTH)) begin : g_bad_c_length
    $error("arbiter_puf_array: C_LENGTH out of range");
  end

  puf_state_e          r_state;
  logic [PW-1:0]       r_phase;
  logic [CW-1:0]       r_eval;
  logic [CW-1:0]       r_cnt [N_CHAINS];
  logic [C_LENGTH-1:0] r_chal;
  logic                r_pulse;
  logic [N_CHAINS-1:0] r_sync1;
  logic [N_CHAINS-1:0] r_sync2;
  logic [N_CHAINS-1:0] w_arb;
  logic [C_LENGTH-1:0] w_chain_chal [N_CHAINS];

  for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
`ifdef PUF_CHAL_SCRAMBLE_EN
    assign w_chain_chal[i] = C_LENGTH'(chal_scramble(CHAL_MAX'(r_chal), C_LENGTH, i));
`else
    assign w_chain_chal[i] = r_chal;
`endif
    puf_chain #(
      .C_LENGTH(C_LENGTH)
    ) u_chain (
      .i_launch   (r_pulse),
      .i_challenge(w_chain_chal[i]),
      .o_arb      (w_arb[i])
    );
  end

  // Arbiter outputs change asynchronously to clk; metastability flops carry no reset.
  always_ff @(posedge clk) begin
    r_sync1 <= w_arb;
    r_sync2 <= r_sync1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_eval     <= '0;
      r_chal     <= '0;
      r_pulse    <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= '0;
      stable     <= '0;
      for (int unsigned i = 0; i < N_CHAINS; i++) r_cnt[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_chal  <= challenge;
            r_phase <= '0;
            r_eval  <= '0;
            busy    <= 1'b1;
            r_state <= DRAIN;
            for (int unsigned i = 0; i < N_CHAINS; i++) r_cnt[i] <= '0;
          end
        end
        DRAIN: begin
          if (r_phase == PW'(SETTLE_CYC - 1)) begin
            r_phase <= '0;
            r_pulse <= 1'b1;
            r_state <= FIRE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        FIRE: begin
          if (r_phase == PW'(SETTLE_CYC - 1)) begin
            r_phase <= '0;
            r_pulse <= 1'b0;
            r_state <= SAMPLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        SAMPLE: begin
          for (int unsigned i = 0; i < N_CHAINS; i++) begin
            r_cnt[i] <= r_cnt[i] + CW'(r_sync2[i]);
          end
          r_eval  <= r_eval + 1'b1;
          r_state <= (r_eval == CW'(N_EVAL - 1)) ? VOTE : DRAIN;
        end
        VOTE: begin
          for (int unsigned i = 0; i < N_CHAINS; i++) begin
            response[i] <= r_cnt[i] > CW'(N_EVAL / 2);
            stable[i]   <= (r_cnt[i] == '0) || (r_cnt[i] == CW'(N_EVAL));
          end
          resp_valid <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_pulse    <= 1'b0;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf_array.sv
// Directed bench for arbiter_puf_array: arbiter outcomes are imposed on the chain
// outputs per evaluation, since zero-delay races have no defined winner.
module tb_arbiter_puf_array;

  localparam int unsigned C_LENGTH   = 8;
  localparam int unsigned N_CHAINS   = 4;
  localparam int unsigned N_EVAL     = 5;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned EVAL_EDGES = 9;
  localparam int unsigned LATENCY    = 46;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [C_LENGTH-1:0] challenge = '0;
  logic                busy;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [N_CHAINS-1:0] response;
  logic [N_CHAINS-1:0] stable;

  logic [N_CHAINS-1:0] r_arb_drv = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [C_LENGTH-1:0]                  chal;
    logic [N_EVAL-1:0][N_CHAINS-1:0]      seq;
    logic [N_CHAINS-1:0]                  exp_resp;
    logic [N_CHAINS-1:0]                  exp_stab;
  } vec_t;

  vec_t vecs [5];

  arbiter_puf_array #(
    .C_LENGTH  (C_LENGTH),
    .N_CHAINS  (N_CHAINS),
    .N_EVAL    (N_EVAL),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .challenge (challenge),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .response  (response),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Accept a challenge, present one arbiter outcome per evaluation, wait for resp_valid.
  task automatic run_txn(input vec_t v, output int lat);
    @(negedge clk);
    challenge = v.chal;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    challenge = ~v.chal;
    r_arb_drv = v.seq[0];
    for (int k = 1; k < N_EVAL; k++) begin
      repeat (EVAL_EDGES) @(posedge clk);
      #1;
      r_arb_drv = v.seq[k];
    end
    lat = (N_EVAL - 1) * EVAL_EDGES;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_txn(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, ".busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   lat;
    int   bad;
    logic [N_CHAINS-1:0] held;
    logic [C_LENGTH-1:0] exp_chal [N_CHAINS];

    force dut.w_arb = r_arb_drv;

    vecs[0] = '{chal: 8'hA5, seq: {4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101},
                exp_resp: 4'b1101, exp_stab: 4'b1111};
    vecs[1] = '{chal: 8'h3C, seq: {4'b1101, 4'b1100, 4'b1101, 4'b1100, 4'b1101},
                exp_resp: 4'b1101, exp_stab: 4'b1110};
    vecs[2] = '{chal: 8'h5A, seq: {4'b1101, 4'b1100, 4'b1101, 4'b1100, 4'b1100},
                exp_resp: 4'b1100, exp_stab: 4'b1110};
    vecs[3] = '{chal: 8'hFF, seq: {4'b0001, 4'b0111, 4'b0011, 4'b0011, 4'b0011},
                exp_resp: 4'b0011, exp_stab: 4'b1001};
    vecs[4] = '{chal: 8'h00, seq: {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                exp_resp: 4'b0000, exp_stab: 4'b1111};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.resp_valid", 32'(resp_valid), 32'd0);
    check("reset.response", 32'(response), 32'd0);
    check("reset.stable", 32'(stable), 32'd0);

    // Table-driven evaluations
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], lat);
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'(LATENCY));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
      check($sformatf("vec%0d.response", i), 32'(response), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d.stable", i), 32'(stable), 32'(vecs[i].exp_stab));
      finish_txn($sformatf("vec%0d", i));
      check($sformatf("vec%0d.response_held", i), 32'(response), 32'(vecs[i].exp_resp));
    end

    // Backpressure: result must stay put while ready is low
    run_txn(vecs[3], lat);
    check("bp.latency", 32'(lat), 32'(LATENCY));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || busy !== 1'b1 ||
          response !== vecs[3].exp_resp || stable !== vecs[3].exp_stab) bad++;
    end
    check("bp.held_cycles_bad", 32'(bad), 32'd0);
    finish_txn("bp");

    // Ready asserted early; start during the handshake cycle is ignored
    @(negedge clk);
    resp_ready = 1'b1;
    run_txn(vecs[4], lat);
    check("early_ready.latency", 32'(lat), 32'(LATENCY));
    check("early_ready.response", 32'(response), 32'(vecs[4].exp_resp));
    start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    resp_ready = 1'b0;
    check("early_ready.valid_drop", 32'(resp_valid), 32'd0);
    check("hs_start.ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("hs_start.still_idle", 32'(busy), 32'd0);

    // Mid-run reset at edge 20 with extra starts while busy
    r_arb_drv = '1;
    @(negedge clk);
    challenge = 8'h77;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort.busy_after_accept", 32'(busy), 32'd1);
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      start = (e == 5) || (e == 12);
      rst   = (e == 20);
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.pulse", 32'(dut.r_pulse), 32'd0);
    check("abort.eval_cnt", 32'(dut.r_eval), 32'd0);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort.stays_idle_bad", 32'(bad), 32'd0);
    run_txn(vecs[0], lat);
    check("abort.fresh_latency", 32'(lat), 32'(LATENCY));
    check("abort.fresh_response", 32'(response), 32'(vecs[0].exp_resp));
    check("abort.fresh_stable", 32'(stable), 32'(vecs[0].exp_stab));
    finish_txn("abort.fresh");

    // Per-chain challenges seen at the chain ports
`ifdef PUF_CHAL_SCRAMBLE_EN
    exp_chal[0] = 8'h01;
    exp_chal[1] = 8'hFD;
    exp_chal[2] = 8'h04;
    exp_chal[3] = 8'hF7;
`else
    for (int i = 0; i < N_CHAINS; i++) exp_chal[i] = 8'h01;
`endif
    @(negedge clk);
    challenge = 8'h01;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    challenge = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N_CHAINS; i++) begin
      check($sformatf("chain%0d.challenge", i), 32'(dut.w_chain_chal[i]), 32'(exp_chal[i]));
    end
    held = response;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("final.busy", 32'(busy), 32'd0);
    check("final.resp_valid", 32'(resp_valid), 32'd0);
    check("final.response_reset", 32'(response), 32'd0);
    check("final.response_before", 32'(held), 32'(vecs[0].exp_resp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
